clk_gen_div_stage: RTL and testbench

//  Programmable 50%-duty clock divider downstream of the 16:1 inverting tap-select mux.

---
 rtl/clk_gen_pkg.sv | 15 +
 rtl/clk_gen_div_settle_cnt.sv | 32 +++
 rtl/clk_gen_div_stage.sv | 115 +++++++++++
 tb/tb_clk_gen_div_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// Shared types and defaults for the tunable block-clock divider and its tuning controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_gen_pkg;

    localparam int CLK_GEN_DIV_WIDTH      = 8;
    localparam int CLK_GEN_STABLE_PERIODS = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } clk_gen_div_state_e;

endpackage

// File: rtl/clk_gen_div_settle_cnt.sv
// Saturating count of completed clk_o periods since the last ratio apply.
// Latency: stable_o is registered, one cycle after the final counted boundary.
// Backpressure: none; clear_i has priority over incr_i.
module clk_gen_div_settle_cnt #(
    parameter int STABLE_PERIODS = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic incr_i,
    output logic stable_o
);

    localparam int CW = $clog2(STABLE_PERIODS + 1);
    localparam logic [CW-1:0] SAT = CW'(STABLE_PERIODS);

    logic [CW-1:0] settle_q;

    // Count period boundaries, hold at the saturation value, restart on a new ratio.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            settle_q <= '0;
        end else if (clear_i) begin
            settle_q <= '0;
        end else if (incr_i && (settle_q != SAT)) begin
            settle_q <= settle_q + 1'b1;
        end
    end

    assign stable_o = (settle_q == SAT);

endmodule

// File: rtl/clk_gen_div_stage.sv
// Programmable 50%-duty divider of the selected oscillator tap; ratio changes land on period ends.
// Latency: clk_o/tick_o registered; first rise div_active_o+1 cycles after leaving IDLE.
// Backpressure: one-deep pending slot; div_ready_o low from capture until the ratio is applied.
module clk_gen_div_stage
    import clk_gen_pkg::*;
#(
    parameter int WIDTH          = CLK_GEN_DIV_WIDTH,
    parameter int STABLE_PERIODS = CLK_GEN_STABLE_PERIODS
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    output logic             clk_o,
    output logic             tick_o,
    output logic [WIDTH-1:0] div_active_o,
    output logic             running_o,
    output logic             stable_o
);

    clk_gen_div_state_e state_q, state_d;
    logic [WIDTH-1:0]   cnt_q;
    logic [WIDTH-1:0]   pend_q;
    logic               half_end;
    logic               boundary;
    logic               apply;
    logic               xfer;

    assign running_o = (state_q == RUN) || (state_q == STOP_PEND);
    assign half_end  = running_o && (cnt_q == div_active_o);
    // clk_o is about to fall: the only point where ratio or run state may change.
    assign boundary  = half_end && clk_o;
    // div_ready_o low means the pending slot holds a ratio waiting to be applied.
    assign apply     = !div_ready_o && ((state_q == IDLE) || boundary);
    assign xfer      = div_valid_i && div_ready_o;

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: stopping waits for the falling edge so the last high phase is never cut short.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (en_i) state_d = RUN;
            RUN:       if (!en_i) state_d = STOP_PEND;
            STOP_PEND: begin
                if (en_i) begin
                    state_d = RUN;
                end else if (boundary) begin
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    // Half-period counter and output clock; parked low with a cleared counter while idle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            clk_o  <= 1'b0;
            tick_o <= 1'b0;
        end else begin
            tick_o <= 1'b0;
            if (running_o) begin
                if (half_end) begin
                    cnt_q  <= '0;
                    clk_o  <= ~clk_o;
                    tick_o <= ~clk_o;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
                clk_o <= 1'b0;
            end
        end
    end

    // Pending ratio slot: capture on handshake, move into the active ratio on apply.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pend_q       <= '0;
            div_ready_o  <= 1'b1;
            div_active_o <= '0;
        end else begin
            if (xfer) begin
                pend_q      <= div_i;
                div_ready_o <= 1'b0;
            end else if (apply) begin
                div_active_o <= pend_q;
                div_ready_o  <= 1'b1;
            end
        end
    end

    clk_gen_div_settle_cnt #(
        .STABLE_PERIODS(STABLE_PERIODS)
    ) u_settle (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (apply),
        .incr_i  (boundary),
        .stable_o(stable_o)
    );

endmodule

// File: tb/tb_clk_gen_div_stage.sv
module tb_clk_gen_div_stage;

    localparam int W  = 8;
    localparam int SP = 4;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         en_i;
    logic [W-1:0] div_i;
    logic         div_valid_i;
    logic         div_ready_o;
    logic         clk_o;
    logic         tick_o;
    logic [W-1:0] div_active_o;
    logic         running_o;
    logic         stable_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    clk_gen_div_stage #(
        .WIDTH         (W),
        .STABLE_PERIODS(SP)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .en_i        (en_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .clk_o       (clk_o),
        .tick_o      (tick_o),
        .div_active_o(div_active_o),
        .running_o   (running_o),
        .stable_o    (stable_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase-remaining countdown, run/stop flags, period tally.
    bit m_clk, m_tick, m_run, m_stop, m_pfull;
    int m_act, m_pend, m_left, m_per;

    task automatic model_reset();
        m_clk = 0; m_tick = 0; m_run = 0; m_stop = 0; m_pfull = 0;
        m_act = 0; m_pend = 0; m_left = 1; m_per = 0;
    endtask

    task automatic model_step();
        bit hs, apply, boundary, phase_end;
        int hs_dat;
        if (reset_i) begin
            model_reset();
            return;
        end
        hs = div_valid_i && !m_pfull;
        hs_dat = int'(div_i);
        apply = 0;
        if (m_run) begin
            phase_end = (m_left == 1);
            boundary  = phase_end && m_clk;
            apply     = m_pfull && boundary;
            m_tick    = phase_end && !m_clk;
            if (phase_end) m_clk = !m_clk;
            if (apply) m_act = m_pend;
            if (phase_end) m_left = m_act + 1;
            else m_left = m_left - 1;
            if (apply) m_per = 0;
            else if (boundary && m_per < SP) m_per = m_per + 1;
            if (m_stop) begin
                if (en_i) m_stop = 0;
                else if (boundary) begin
                    m_run = 0;
                    m_stop = 0;
                end
            end else if (!en_i) begin
                m_stop = 1;
            end
        end else begin
            m_tick = 0;
            m_clk  = 0;
            apply  = m_pfull;
            if (apply) begin
                m_act = m_pend;
                m_per = 0;
            end
            if (en_i) m_run = 1;
            m_left = m_act + 1;
        end
        if (apply) m_pfull = 0;
        if (hs) begin
            m_pfull = 1;
            m_pend  = hs_dat;
        end
    endtask

    task automatic compare_all();
        check("clk_o",        clk_o,        m_clk);
        check("tick_o",       tick_o,       m_tick);
        check("div_active_o", div_active_o, m_act);
        check("div_ready_o",  div_ready_o,  !m_pfull);
        check("running_o",    running_o,    m_run);
        check("stable_o",     stable_o,     (m_per == SP));
    endtask

    task automatic cyc();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic wait_tick(input string tag);
        for (int i = 0; i < 40 && !m_tick; i++) cyc();
        check(tag, tick_o, 1);
    endtask

    initial begin
        reset_i = 1'b1; en_i = 1'b0; div_valid_i = 1'b0; div_i = '0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check("rst_clk_o",   clk_o,        0);
        check("rst_tick_o",  tick_o,       0);
        check("rst_active",  div_active_o, 0);
        check("rst_ready",   div_ready_o,  1);
        check("rst_running", running_o,    0);
        check("rst_stable",  stable_o,     0);
        reset_i = 1'b0;

        // Divide-by-2 from reset ratio.
        en_i = 1'b1;
        repeat (14) cyc();
        check("div2_stable", stable_o, 1);
        en_i = 1'b0;
        repeat (6) cyc();

        // Load while idle, then run 4/4.
        div_valid_i = 1'b1; div_i = 8'd3;
        cyc();
        div_valid_i = 1'b0; div_i = W'($urandom);
        cyc();
        check("load_idle", div_active_o, 3);
        en_i = 1'b1;
        repeat (40) cyc();
        check("div3_stable", stable_o, 1);

        // Mid high-phase load; a second valid while not ready is ignored.
        wait_tick("wait_tick_load");
        cyc();
        div_valid_i = 1'b1; div_i = 8'd1;
        cyc();
        div_i = 8'd5;
        cyc();
        div_valid_i = 1'b0;
        repeat (20) cyc();
        check("first_wins", div_active_o, 1);

        // Stop one cycle into a high phase.
        wait_tick("wait_tick_stop");
        cyc();
        en_i = 1'b0;
        repeat (10) cyc();
        check("parked", running_o, 0);

        // Re-enable while a stop is pending.
        en_i = 1'b1;
        wait_tick("wait_tick_reen");
        cyc();
        en_i = 1'b0;
        cyc();
        en_i = 1'b1;
        repeat (12) cyc();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) en_i = ~en_i;
            div_valid_i = ($urandom_range(0, 3) == 0);
            div_i = W'($urandom_range(0, 5));
            cyc();
        end

        // Asynchronous reset while clk_o is high, with a ratio pending.
        en_i = 1'b1; div_valid_i = 1'b0;
        repeat (3) cyc();
        for (int i = 0; i < 40 && !m_clk; i++) cyc();
        check("pre_rst_clk_high", clk_o, 1);
        if (div_ready_o) begin
            div_valid_i = 1'b1; div_i = 8'd7;
            cyc();
            div_valid_i = 1'b0;
        end
        for (int i = 0; i < 40 && !m_clk; i++) cyc();
        #2;
        reset_i = 1'b1;
        model_reset();
        #1;
        check("async_clk_o",  clk_o,        0);
        check("async_ready",  div_ready_o,  1);
        check("async_active", div_active_o, 0);
        check("async_no_edge", clk_i,       0);
        en_i = 1'b0;
        cyc();
        reset_i = 1'b0;
        repeat (4) cyc();
        en_i = 1'b1;
        repeat (10) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
